// File: rtl/cache_mem_arbiter.sv
// Two-port (icache/dcache) to single memory port arbiter with one-cycle arbitration latency.
// Define ARB_RR_EN for round-robin tie breaking; the default build gives dcache fixed priority.
module cache_mem_arbiter #(
    parameter int A_WIDTH = 32,
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [A_WIDTH-1:0] i_a,
    input  logic [D_WIDTH-1:0] i_din,
    input  logic               i_strobe,
    input  logic               i_rw,
    output logic               i_ready,
    output logic [D_WIDTH-1:0] i_dout,
    input  logic [A_WIDTH-1:0] d_a,
    input  logic [D_WIDTH-1:0] d_din,
    input  logic               d_strobe,
    input  logic               d_rw,
    output logic               d_ready,
    output logic [D_WIDTH-1:0] d_dout,
    output logic [A_WIDTH-1:0] mem_a,
    output logic [D_WIDTH-1:0] mem_din,
    output logic               mem_strobe,
    output logic               mem_rw,
    input  logic               mem_ready,
    input  logic [D_WIDTH-1:0] mem_dout,
    output logic               gnt_i,
    output logic               gnt_d
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   tie_to_d;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

`ifdef ARB_RR_EN
    // Remembers who was granted most recently; the other port wins the next tie.
    logic last_d;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            last_d <= 1'b1;
        end else if (state == IDLE && state_next != IDLE) begin
            last_d <= (state_next == GNT_D);
        end
    end

    assign tie_to_d = !last_d;
`else
    assign tie_to_d = 1'b1;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (d_strobe && (!i_strobe || tie_to_d)) begin
                    state_next = GNT_D;
                end else if (i_strobe) begin
                    state_next = GNT_I;
                end
            end
            // Completion or abort both return to IDLE, forcing an idle cycle.
            GNT_I: begin
                if (mem_ready || !i_strobe) begin
                    state_next = IDLE;
                end
            end
            GNT_D: begin
                if (mem_ready || !d_strobe) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_a      = '0;
        mem_din    = '0;
        mem_rw     = 1'b0;
        mem_strobe = 1'b0;
        i_ready    = 1'b0;
        d_ready    = 1'b0;
        case (state)
            GNT_I: begin
                mem_a      = i_a;
                mem_din    = i_din;
                mem_rw     = i_rw;
                mem_strobe = i_strobe;
                i_ready    = mem_ready;
            end
            GNT_D: begin
                mem_a      = d_a;
                mem_din    = d_din;
                mem_rw     = d_rw;
                mem_strobe = d_strobe;
                d_ready    = mem_ready;
            end
            default: ;
        endcase
    end

    assign gnt_i  = (state == GNT_I);
    assign gnt_d  = (state == GNT_D);
    assign i_dout = mem_dout;
    assign d_dout = mem_dout;

endmodule
